// File: rtl/bsw_pkg.sv
// Shared types and widths for the banded Smith-Waterman job scheduler.
package bsw_pkg;

    localparam int SEQ_W = 24;
    localparam int RES_W = 27;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        STORE
    } state_t;

    typedef struct packed {
        logic             timeout;
        logic [RES_W-1:0] r_aligned;
        logic [RES_W-1:0] q_aligned;
    } result_t;

endpackage

// File: rtl/bsw_result_fifo.sv
// First-word fall-through result FIFO; the head is visible whenever it is non-empty.
module bsw_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty gates the read data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bsw_job_scheduler.sv
// Runs one alignment job at a time on the accelerator and queues its results.
module bsw_job_scheduler
    import bsw_pkg::*;
#(
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4096,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [SEQ_W-1:0] job_r,
    input  logic [SEQ_W-1:0] job_q,
    output logic             acc_start,
    output logic [SEQ_W-1:0] acc_r,
    output logic [SEQ_W-1:0] acc_q,
    input  logic             acc_ready,
    input  logic [RES_W-1:0] acc_r_aligned,
    input  logic [RES_W-1:0] acc_q_aligned,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_r_aligned,
    output logic [RES_W-1:0] res_q_aligned,
    output logic             res_timeout,
    output logic             busy,
    output logic [15:0]      jobs_done
);
    localparam int CYC_W = $clog2(TIMEOUT);
    localparam int SC_W  = (START_CYC > 1) ? $clog2(START_CYC) : 1;

    state_t           state;
    state_t           state_next;
    logic [SC_W-1:0]  start_cnt;
    logic [CYC_W-1:0] cyc;
    result_t          captured;
    result_t          head;
    logic             run_hit;
    logic             run_expire;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    // Ready in the first RUN cycle may be left over from the previous job.
    assign run_hit    = (state == RUN) && (cyc != '0) && acc_ready;
    assign run_expire = (state == RUN) && (cyc == CYC_W'(TIMEOUT - 1));
    assign pop        = res_valid && res_ready;
    assign push       = (state == STORE) && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        job_ready  = 1'b0;
        acc_start  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) state_next = START;
            end
            START: begin
                acc_start = 1'b1;
                if (start_cnt == '0) state_next = RUN;
            end
            RUN: begin
                if (run_hit || run_expire) state_next = STORE;
            end
            STORE: begin
                if (push) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Job operands, phase counters, result capture and the completion count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r     <= '0;
            acc_q     <= '0;
            start_cnt <= '0;
            cyc       <= '0;
            captured  <= '0;
            jobs_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        acc_r     <= job_r;
                        acc_q     <= job_q;
                        start_cnt <= SC_W'(START_CYC - 1);
                    end
                end
                START: begin
                    cyc <= '0;
                    if (start_cnt != '0) start_cnt <= start_cnt - SC_W'(1);
                end
                RUN: begin
                    if (run_hit) begin
                        captured <= '{timeout: 1'b0, r_aligned: acc_r_aligned, q_aligned: acc_q_aligned};
                    end else if (run_expire) begin
                        captured <= '{timeout: 1'b1, r_aligned: '0, q_aligned: '0};
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                STORE: begin
                    if (push) jobs_done <= jobs_done + 16'd1;
                end
                default: ;
            endcase
        end
    end

    bsw_result_fifo #(
        .WIDTH($bits(result_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (captured),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign res_valid     = !fifo_empty;
    assign res_r_aligned = head.r_aligned;
    assign res_q_aligned = head.q_aligned;
    assign res_timeout   = head.timeout;

endmodule

// File: tb/tb_bsw_job_scheduler.sv
// Bench for bsw_job_scheduler: job table plus hand-built stale-ready, backpressure, reset and wrap sequences.
module tb_bsw_job_scheduler;

    localparam int START_CYC = 2;
    localparam int TIMEOUT   = 16;
    localparam int DEPTH     = 4;

    typedef struct {
        logic [23:0] r;
        logic [23:0] q;
        int          delay;
        logic [26:0] ar;
        logic [26:0] aq;
        logic        exp_to;
        logic [26:0] exp_r;
        logic [26:0] exp_q;
        int          exp_lat;
    } job_vec_t;

    typedef struct packed {
        logic        to;
        logic [26:0] r;
        logic [26:0] q;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [23:0] job_r;
    logic [23:0] job_q;
    logic        acc_start;
    logic [23:0] acc_r;
    logic [23:0] acc_q;
    logic        acc_ready;
    logic [26:0] acc_r_aligned;
    logic [26:0] acc_q_aligned;
    logic        res_valid;
    logic        res_ready;
    logic [26:0] res_r_aligned;
    logic [26:0] res_q_aligned;
    logic        res_timeout;
    logic        busy;
    logic [15:0] jobs_done;

    logic        autoMode;
    logic        manReady;
    logic [26:0] manR;
    logic [26:0] manQ;
    logic [15:0] expDone;
    int          testsRun;
    int          testsFailed;
    exp_t        sbQ[$];
    job_vec_t    tbl[5];

    // Accelerator model: manual per-job control, or always-ready with data derived from acc_r/acc_q.
    assign acc_ready     = autoMode ? 1'b1 : manReady;
    assign acc_r_aligned = autoMode ? {3'b000, acc_r} : manR;
    assign acc_q_aligned = autoMode ? {3'b101, acc_q} : manQ;

    always #5 clk = ~clk;

    bsw_job_scheduler #(
        .START_CYC(START_CYC),
        .TIMEOUT  (TIMEOUT),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_r        (job_r),
        .job_q        (job_q),
        .acc_start    (acc_start),
        .acc_r        (acc_r),
        .acc_q        (acc_q),
        .acc_ready    (acc_ready),
        .acc_r_aligned(acc_r_aligned),
        .acc_q_aligned(acc_q_aligned),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_r_aligned(res_r_aligned),
        .res_q_aligned(res_q_aligned),
        .res_timeout  (res_timeout),
        .busy         (busy),
        .jobs_done    (jobs_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer one job at a negedge and return at the negedge after it was accepted.
    task automatic applyStimulus(input logic [23:0] r, input logic [23:0] q);
        int n;
        @(negedge clk);
        job_valid = 1'b1;
        job_r     = r;
        job_q     = q;
        n = 0;
        while (!job_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_wait", 32'(n < 100), 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic popAndCheck(input string name);
        exp_t e;
        checkOutput({name, "_valid"}, 32'(res_valid), 32'd1);
        if (sbQ.size() == 0) begin
            checkOutput({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbQ.pop_front();
            checkOutput({name, "_r"}, 32'(res_r_aligned), 32'(e.r));
            checkOutput({name, "_q"}, 32'(res_q_aligned), 32'(e.q));
            checkOutput({name, "_to"}, 32'(res_timeout), 32'(e.to));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic countStart(input string name);
        int n;
        n = 0;
        while (acc_start && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput(name, 32'(n), 32'(START_CYC));
    endtask

    task automatic runJob(input job_vec_t v, input string name);
        int lat;
        sbQ.push_back('{to: v.exp_to, r: v.exp_r, q: v.exp_q});
        manReady = 1'b0;
        manR     = v.ar;
        manQ     = v.aq;
        applyStimulus(v.r, v.q);
        countStart({name, "_start_cycles"});
        checkOutput({name, "_acc_r"}, 32'(acc_r), 32'(v.r));
        checkOutput({name, "_acc_q"}, 32'(acc_q), 32'(v.q));
        lat = 0;
        while (!res_valid && lat < 40) begin
            if (lat == v.delay) manReady = 1'b1;
            @(negedge clk);
            lat++;
        end
        manReady = 1'b0;
        checkOutput({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        expDone++;
        checkOutput({name, "_jobs_done"}, 32'(jobs_done), 32'(expDone));
        popAndCheck(name);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        logic [23:0] bpR;
        testsRun    = 0;
        testsFailed = 0;
        expDone     = 16'd0;
        autoMode    = 1'b0;
        manReady    = 1'b0;
        manR        = '0;
        manQ        = '0;
        job_valid   = 1'b0;
        job_r       = '0;
        job_q       = '0;
        res_ready   = 1'b0;
        reset       = 1'b1;

        // Latency counts negedges from the first RUN cycle; ready is raised in RUN cycle 'delay'.
        tbl[0] = '{24'h0A1B2C, 24'h0A1B2D, 10, 27'h1234567, 27'h7654321, 1'b0, 27'h1234567, 27'h7654321, 12};
        tbl[1] = '{24'hFFFFFF, 24'h000000, 1, 27'h7FFFFFF, 27'h0000001, 1'b0, 27'h7FFFFFF, 27'h0000001, 3};
        tbl[2] = '{24'h123456, 24'h654321, 15, 27'h5A5A5A5, 27'h2A5A5A5, 1'b0, 27'h5A5A5A5, 27'h2A5A5A5, 17};
        tbl[3] = '{24'hABCDEF, 24'hFEDCBA, 200, 27'h1111111, 27'h2222222, 1'b1, 27'h0000000, 27'h0000000, 17};
        tbl[4] = '{24'h000001, 24'h800000, 5, 27'h0000ABC, 27'h4000DEF, 1'b0, 27'h0000ABC, 27'h4000DEF, 7};

        #3;
        checkOutput("rst_acc_start", 32'(acc_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_jobs_done", 32'(jobs_done), 32'd0);
        checkOutput("rst_acc_r", 32'(acc_r), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_job_ready", 32'(job_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            runJob(tbl[i], $sformatf("job%0d", i));
        end

        // Ready left high from before the job: only the second RUN cycle may capture.
        sbQ.push_back('{to: 1'b0, r: 27'h0BBBBBB, q: 27'h0CCCCCC});
        manReady = 1'b1;
        manR     = 27'h1AAAAAA;
        manQ     = 27'h1AAAAAA;
        applyStimulus(24'h111111, 24'h222222);
        countStart("stale_start_cycles");
        @(negedge clk);
        manR = 27'h0BBBBBB;
        manQ = 27'h0CCCCCC;
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        manReady = 1'b0;
        checkOutput("stale_latency", 32'(lat), 32'd3);
        expDone++;
        popAndCheck("stale");

        // Five jobs with the consumer stalled: the fifth waits in STORE.
        autoMode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bpR = 24'h100000 + 24'(k);
            sbQ.push_back('{to: 1'b0, r: {3'b000, bpR}, q: {3'b101, ~bpR}});
            applyStimulus(bpR, ~bpR);
        end
        repeat (12) @(negedge clk);
        expDone = expDone + 16'd4;
        checkOutput("bp_job_ready", 32'(job_ready), 32'd0);
        checkOutput("bp_busy", 32'(busy), 32'd1);
        checkOutput("bp_jobs_done", 32'(jobs_done), 32'(expDone));
        checkOutput("bp_acc_r_held", 32'(acc_r), 32'h100004);
        popAndCheck("bp_head");
        expDone++;
        checkOutput("bp_push_same_cycle", 32'(jobs_done), 32'(expDone));
        checkOutput("bp_idle_again", 32'(job_ready), 32'd1);
        autoMode = 1'b0;
        for (int k = 0; k < 4; k++) popAndCheck($sformatf("bp_order%0d", k));
        checkOutput("bp_drained", 32'(res_valid), 32'd0);

        // Asynchronous reset between edges while the accelerator is running.
        manReady = 1'b0;
        applyStimulus(24'h333333, 24'h444444);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_acc_start", 32'(acc_start), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("arst_acc_r", 32'(acc_r), 32'd0);
        checkOutput("arst_jobs_done", 32'(jobs_done), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        expDone = 16'd0;
        repeat (3) @(negedge clk);
        checkOutput("arst_no_entry", 32'(res_valid), 32'd0);
        runJob(tbl[1], "after_rst");

        // Completion counter wraps from 0xFFFF to 0.
        @(negedge clk);
        dut.jobs_done = 16'hFFFF;
        expDone       = 16'hFFFF;
        runJob(tbl[4], "wrap");
        checkOutput("wrap_zero", 32'(jobs_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
